mc_datapath: RTL and testbench
==============================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning datapath/register/memory word width (>=32; instruction fields always decoded from bits [31:0]).
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, meaning register-file address width (2**REG_ADDR_WIDTH registers).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 mem_req  output  1  memory access request; held until mem_ready.
REQ-007 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-008 mem_addr  output  DATA_WIDTH  byte address (PC on fetch, ALUOut on data access).
REQ-009 mem_wdata  output  DATA_WIDTH  store data (rt register value).
REQ-010 mem_rdata  input  DATA_WIDTH  read data, sampled on the cycle mem_req & mem_ready & !mem_we.
REQ-011 mem_ready  input  1  access completes on the cycle it is high with mem_req.
REQ-012 pc  output  DATA_WIDTH  current PC register.
REQ-013 instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
REQ-014 illegal  output  1  one-cycle pulse when DECODE sees an unsupported opcode/funct.

Function
REQ-015 SHALL implement a Moore FSM: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready latch IR<=mem_rdata, pc<=pc+4, go DECODE; else stay, outputs stable.
REQ-017 DECODE: latch A<=RF[rs], B<=RF[rt], ALUOut<=pc+(signext(imm)<<2); branch on opcode: lw/sw->MEMADR, R-type->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP, other->FETCH with illegal=1.
REQ-018 MEMADR: ALUOut<=A+signext(imm); lw->MEMRD, sw->MEMWR.
REQ-019 MEMRD: read at ALUOut; on mem_ready latch MDR, go MEMWB; MEMWB: RF[rt]<=MDR, ->FETCH.
REQ-020 MEMWR: write B to ALUOut; on mem_ready ->FETCH.
REQ-021 EXEC: ALUOut<=A op B for funct add(0x20), sub(0x22), and(0x24), or(0x25), slt(0x2A); ALUWB: RF[rd]<=ALUOut, ->FETCH; unsupported funct treated as illegal in DECODE.
REQ-022 BRANCH: if A==B then pc<=ALUOut; ->FETCH.
REQ-023 ADDIEX: ALUOut<=A+signext(imm); ADDIWB: RF[rt]<=ALUOut, ->FETCH.
REQ-024 JUMP: pc<={pc[DATA_WIDTH-1:28], IR[25:0], 2'b00}; ->FETCH.
REQ-025 Sign extension SHALL replicate imm[15] to DATA_WIDTH; all adds wrap modulo 2**DATA_WIDTH, no overflow trap; slt is signed.
REQ-026 Register 0 SHALL read as 0; writes to it SHALL be discarded.
REQ-027 instr_done SHALL pulse in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, DECODE(illegal), and the completing cycle of MEMWR.
REQ-028 Zero-wait latencies: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each wait cycle (mem_ready=0) adds 1.
REQ-029 mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-030 RST=0 SHALL immediately force state=FETCH, pc=RESET_PC, IR/A/B/ALUOut/MDR=0, all registers=0, mem_req=0 while asserted, instr_done=0, illegal=0.
REQ-031 Reset mid-access SHALL drop mem_req asynchronously; first FETCH request issued on the first clock edge after RST returns high.

Configuration
REQ-032 Macro MC_DATAPATH_BNE_EN: when defined, opcode 0x05 (bne) SHALL go DECODE->BRANCH and take the branch if A!=B; when undefined, opcode 0x05 SHALL be illegal.

Verification
REQ-033 Reset, zero-wait memory, addi $1,$0,5 at 0 -> pc 0->4, RF[1]=5 after 4 cycles, one instr_done.
REQ-034 lw $2,8($0) with mem[8]=0xDEADBEEF, mem_ready low 3 cycles on data read -> RF[2]=0xDEADBEEF, 8 cycles total, mem_addr stable at 8 during wait.
REQ-035 beq $1,$1,-1 at 0x10 -> pc=0x10 after 3 cycles (loop); beq $1,$2 unequal -> pc=0x14.
REQ-036 j 0x100 at 0x20 -> pc=0x400; sw $1,4($0) -> mem_we=1, mem_addr=4, mem_wdata=RF[1].
REQ-037 opcode 0x3F -> illegal pulse, pc+4, no register/memory write; bne per MC_DATAPATH_BNE_EN both builds.
REQ-038 RST low during MEMRD wait -> mem_req=0 at once, pc=RESET_PC, first fetch at RESET_PC after release.

Source files
------------

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath: shared memory port, Moore control FSM.
// Define MC_DATAPATH_BNE_EN to add bne (opcode 0x05) to the instruction set.
module mc_datapath #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  RST,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  instr_done,
    output logic                  illegal
);

    localparam int NREG = 2 ** REG_ADDR_WIDTH;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;

    state_t                  state;
    state_t                  dec_next;
    logic                    dec_ill;
    logic                    run;
    logic                    acc;
    logic                    take;
    logic [31:0]             ir;
    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic [DATA_WIDTH-1:0]   alu_out;
    logic [DATA_WIDTH-1:0]   mdr;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic [DATA_WIDTH-1:0]   imm_ext;
    logic [DATA_WIDTH-1:0]   rf [NREG];
    logic [5:0]              op;
    logic [5:0]              funct;
    logic [REG_ADDR_WIDTH-1:0] rs_idx;
    logic [REG_ADDR_WIDTH-1:0] rt_idx;
    logic [REG_ADDR_WIDTH-1:0] rd_idx;
    logic                    unused_shamt;

    assign op           = ir[31:26];
    assign funct        = ir[5:0];
    assign rs_idx       = REG_ADDR_WIDTH'(ir[25:21]);
    assign rt_idx       = REG_ADDR_WIDTH'(ir[20:16]);
    assign rd_idx       = REG_ADDR_WIDTH'(ir[15:11]);
    assign imm_ext      = {{(DATA_WIDTH-16){ir[15]}}, ir[15:0]};
    assign unused_shamt = ^ir[10:6];

    always_comb begin
        dec_next = FETCH;
        dec_ill  = 1'b0;
        case (op)
            OP_LW, OP_SW: dec_next = MEMADR;
            OP_BEQ:       dec_next = BRANCH;
`ifdef MC_DATAPATH_BNE_EN
            OP_BNE:       dec_next = BRANCH;
`endif
            OP_ADDI:      dec_next = ADDIEX;
            OP_J:         dec_next = JUMP;
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: dec_next = EXEC;
                    default:                          dec_ill  = 1'b1;
                endcase
            end
            default:      dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (funct)
            F_ADD:   alu_res = a + b;
            F_SUB:   alu_res = a - b;
            F_AND:   alu_res = a & b;
            F_OR:    alu_res = a | b;
            F_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: alu_res = '0;
        endcase
    end

`ifdef MC_DATAPATH_BNE_EN
    assign take = (op == OP_BNE) ? (a != b) : (a == b);
`else
    assign take = (a == b);
`endif

    // run gates the first request until one edge after reset release
    assign mem_req   = run & ((state == FETCH) | (state == MEMRD) | (state == MEMWR));
    assign mem_we    = (state == MEMWR);
    assign mem_addr  = (state == FETCH) ? pc : alu_out;
    assign mem_wdata = b;
    assign acc       = mem_req & mem_ready;

    assign illegal    = (state == DECODE) & dec_ill;
    assign instr_done = (state == MEMWB) | (state == ALUWB) | (state == ADDIWB)
                      | (state == BRANCH) | (state == JUMP) | illegal
                      | ((state == MEMWR) & acc);

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state   <= FETCH;
            run     <= 1'b0;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            run <= 1'b1;
            unique case (state)
                FETCH: begin
                    if (acc) begin
                        ir    <= mem_rdata[31:0];
                        pc    <= pc + DATA_WIDTH'(4);
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a       <= rf[rs_idx];
                    b       <= rf[rt_idx];
                    alu_out <= pc + (imm_ext << 2);
                    state   <= dec_next;
                end
                MEMADR: begin
                    alu_out <= a + imm_ext;
                    state   <= (op == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    if (acc) begin
                        mdr   <= mem_rdata;
                        state <= MEMWB;
                    end
                end
                MEMWB: begin
                    if (rt_idx != '0) rf[rt_idx] <= mdr;
                    state <= FETCH;
                end
                MEMWR: begin
                    if (acc) state <= FETCH;
                end
                EXEC: begin
                    alu_out <= alu_res;
                    state   <= ALUWB;
                end
                ALUWB: begin
                    if (rd_idx != '0) rf[rd_idx] <= alu_out;
                    state <= FETCH;
                end
                BRANCH: begin
                    if (take) pc <= alu_out;
                    state <= FETCH;
                end
                ADDIEX: begin
                    alu_out <= a + imm_ext;
                    state   <= ADDIWB;
                end
                ADDIWB: begin
                    if (rt_idx != '0) rf[rt_idx] <= alu_out;
                    state <= FETCH;
                end
                JUMP: begin
                    pc    <= {pc[DATA_WIDTH-1:28], ir[25:0], 2'b00};
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: random program vs. an instruction-level model,
// random memory wait states, and a reset during a stalled data read.
module tb_mc_datapath;

    localparam logic [31:0] END_PC = 32'h110;

    logic        clk = 1'b0;
    logic        RST;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] pc;
    logic        instr_done;
    logic        illegal;

    mc_datapath dut (
        .clk        (clk),
        .RST        (RST),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [31:0] mem  [256];
    logic [31:0] rmem [256];
    logic [31:0] rf   [32];
    logic [31:0] rpc;

    assign mem_rdata = mem[mem_addr[9:2]];

    int n_chk = 0;
    int n_fail = 0;
    int cyc, waits, wr_cnt;
    bit active, pc_pend, chk_en, hold, done_flag, at_end, found;
    bit e_ill, e_st;
    int e_lat;
    logic [31:0] e_sa, e_sd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] rand_instr(input int w);
        logic [5:0] fns [6];
        logic [4:0] rs, rt, rd;
        logic [15:0] dofs;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        dofs = 16'(32'h200 + 4 * $urandom_range(0, 63));
        case ($urandom_range(0, 9))
            0, 1: return enc_i(6'h08, rs, rt, 16'($urandom));
            2, 3: return enc_r(rs, rt, rd, fns[$urandom_range(0, 5)]);
            4: return enc_i(6'h23, 5'd0, rt, dofs);
            5: return enc_i(6'h2B, 5'd0, rt, dofs);
            6: return enc_i(6'h04, rs, rt, 16'($urandom_range(1, 2)));
            7: return enc_i(6'h05, rs, rt, 16'($urandom_range(1, 2)));
            8: return {6'h02, 26'(w + 2)};
            default: return {6'h3F, 26'($urandom)};
        endcase
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1]  = enc_i(6'h23, 5'd0, 5'd2, 16'h0208);
        mem[2]  = enc_i(6'h04, 5'd1, 5'd1, 16'd1);
        mem[3]  = 32'hFC000000;
        mem[4]  = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
        mem[5]  = {6'h02, 26'd7};
        mem[6]  = enc_i(6'h08, 5'd0, 5'd3, 16'd1);
        mem[7]  = 32'hFC000000;
        mem[8]  = enc_i(6'h05, 5'd1, 5'd2, 16'd1);
        mem[9]  = enc_i(6'h08, 5'd0, 5'd4, 16'hFFFF);
        mem[10] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0204);
        mem[11] = enc_r(5'd1, 5'd2, 5'd3, 6'h2A);
        mem[12] = enc_r(5'd2, 5'd1, 5'd5, 6'h22);
        for (int w = 13; w <= 60; w++) mem[w] = rand_instr(w);
        for (int r = 1; r <= 7; r++)
            mem[60 + r] = enc_i(6'h2B, 5'd0, 5'(r), 16'(32'h300 + 4 * r));
        mem[68]  = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
        mem[130] = 32'hDEADBEEF;
        for (int i = 0; i < 256; i++) rmem[i] = mem[i];
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rpc = '0;
    endtask

    task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) rf[r] = v;
    endtask

    // Executes one instruction of the architectural model at rpc.
    task automatic step(output bit ill, output int lat, output bit st,
                        output logic [31:0] sa, output logic [31:0] sd);
        logic [31:0] ins, a, b, simm, npc, r, ea;
        ins  = rmem[rpc[9:2]];
        a    = rf[ins[25:21]];
        b    = rf[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        npc  = rpc + 4;
        ill = 0; st = 0; sa = '0; sd = '0; lat = 2; r = '0;
        case (ins[31:26])
            6'h00: begin
                lat = 4;
                case (ins[5:0])
                    6'h20: r = a + b;
                    6'h22: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: begin ill = 1; lat = 2; end
                endcase
                if (!ill) wr_reg(ins[15:11], r);
            end
            6'h23: begin
                lat = 5;
                ea = a + simm;
                wr_reg(ins[20:16], rmem[ea[9:2]]);
            end
            6'h2B: begin
                lat = 4; st = 1; sa = a + simm; sd = b;
                rmem[sa[9:2]] = b;
            end
            6'h04: begin
                lat = 3;
                if (a == b) npc = npc + (simm << 2);
            end
`ifdef MC_DATAPATH_BNE_EN
            6'h05: begin
                lat = 3;
                if (a != b) npc = npc + (simm << 2);
            end
`endif
            6'h08: begin
                lat = 4;
                wr_reg(ins[20:16], a + simm);
            end
            6'h02: begin
                lat = 3;
                npc = {npc[31:28], ins[25:0], 2'b00};
            end
            default: ill = 1;
        endcase
        rpc = npc;
    endtask

    // One negedge: drive mem_ready for the coming edge, then observe.
    task mon();
        if (hold && mem_req && !mem_we && mem_addr == 32'h208) mem_ready = 1'b0;
        else mem_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (!RST) begin
            active = 0; cyc = 0; waits = 0; wr_cnt = 0; pc_pend = 0;
            return;
        end
        if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata;
            wr_cnt++;
        end
        if (!chk_en) return;
        if (pc_pend) begin
            check("pc", pc, rpc);
            pc_pend = 0;
        end
        if (mem_req) active = 1;
        if (active) begin
            cyc++;
            if (mem_req && !mem_ready) waits++;
        end
        if (instr_done) begin
            at_end = (rpc == END_PC);
            step(e_ill, e_lat, e_st, e_sa, e_sd);
            check("illegal", 32'(illegal), 32'(e_ill));
            check("cycles", cyc, e_lat + waits);
            check("writes", wr_cnt, 32'(e_st));
            if (e_st) begin
                check("st_addr", mem_addr, e_sa);
                check("st_data", mem_wdata, e_sd);
            end
            pc_pend = 1; cyc = 0; waits = 0; wr_cnt = 0;
            if (at_end) done_flag = 1;
        end
    endtask

    initial begin
        RST = 1'b0; mem_ready = 1'b0; hold = 0; chk_en = 1; done_flag = 0;
        active = 0; pc_pend = 0; cyc = 0; waits = 0; wr_cnt = 0;
        load_prog();
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_done", 32'(instr_done), 32'h0);
        check("rst_ill", 32'(illegal), 32'h0);
        RST = 1'b1;
        #1;
        check("rel_req", 32'(mem_req), 32'h0);

        for (int i = 0; i < 6000 && !done_flag; i++) begin
            @(negedge clk);
            mon();
        end
        check("prog_done", 32'(done_flag), 32'h1);

        chk_en = 0;
        hold = 1;
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            mon();
            found = mem_req && !mem_we && mem_addr == 32'h208;
        end
        check("rd_wait_seen", 32'(found), 32'h1);
        @(negedge clk);
        mon();
        check("rd_held_req", 32'(mem_req), 32'h1);
        check("rd_held_addr", mem_addr, 32'h208);
        RST = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'h0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_done", 32'(instr_done), 32'h0);
        @(negedge clk);
        RST = 1'b1;
        #1;
        check("post_rel_req", 32'(mem_req), 32'h0);
        @(posedge clk);
        #1;
        check("first_req", 32'(mem_req), 32'h1);
        check("first_addr", mem_addr, 32'h0);
        check("first_we", 32'(mem_we), 32'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
